pcm_nch_player: RTL and testbench
=================================

# pcm_nch_player

Parametrised N-channel PCM sample player, successor to the two-channel Konami-style sample chip. A round-robin slot sequencer fetches one byte per channel per round from a shared sample ROM. Per-channel prescalers and address counters, with an end-marker bit in the sample data, provide one-shot and looped playback. New behaviour: NCH channels, per-channel 4-bit volume, explicit key-off, and a busy status vector. The block sits between the CPU register bus and the sample ROM, feeding per-channel DACs/mixer.

## Interface
- NCH, 4: channel count (≥1).
- AW, 17: sample address width.
- PW, 12: prescaler width (9..16).
- DW, 7: sample magnitude width; end marker is SD[DW].
- CLK in 1: single clock.
- NRES in 1: reset, asynchronous, active-low.
- WR in 1: register write strobe, one cycle, sampled on CLK rise.
- ADDR in $clog2(NCH)+3: {channel, reg[2:0]}.
- DIN in 8: write data.
- SA out AW: sample ROM address.
- SD in DW+1: ROM data for SA, valid one cycle after SA.
- CH_OUT out NCH*DW: per-channel scaled sample, channel c at [c*DW +: DW].
- STATUS out NCH: per-channel busy.
- TICK out 1: high in last cycle of each round.

## Operation
- Per-channel registers (reg index):
  - 0: period[7:0].
  - 1: period[PW-1:8].
  - 2–4: start[7:0], [15:8], [AW-1:16].
  - 5: bit0 loop, bits7:4 vol.
  - 6: key-on, data ignored.
  - 7: key-off, data ignored.
- Key-on: addr←start, pre←period, busy←1. A key-on while busy restarts playback.
- Key-off: busy←0; CH_OUT holds its last value.
- Sequencer: slot counter 0..2*NCH-1, channel s = slot>>1, phase = slot[0]. SA = addr[s] in both phases.
- Phase 1 capture, busy channels only:
  - SD[DW]=1, loop=1: addr←start, pre←period, CH_OUT unchanged.
  - SD[DW]=1, loop=0: busy←0, CH_OUT unchanged.
  - SD[DW]=0: CH_OUT[s] ← (SD[DW-1:0]*(vol+1))>>4, so vol=15 passes the sample unchanged. Then if pre is all-ones, addr←addr+1 (wraps 2^AW-1→0) and pre←period; otherwise pre←pre+1.
- Step interval: one step every 2^PW−period rounds.
- Idle channels: SA is still presented; no state changes.
- Simultaneous events:
  - Key-on/key-off on the channel being captured wins over the capture update.
  - A register write to the period/start/ctl of a busy channel takes effect at its next reload or capture.

## Timing
- Round = 2*NCH cycles. Each channel is fetched once per round.
- SA is combinational from the registered slot/addr.
- SD is sampled at the CLK edge ending phase 1.
- CH_OUT and STATUS update on that edge.
- Register writes are visible on the edge that samples WR. STATUS reflects key-on/key-off the cycle after WR.
- Reset (async assert, sync release inside the block), all outputs and state:
  - slot=0, SA=0, TICK=0.
  - All registers, addr, pre, busy = 0; CH_OUT=0; STATUS=0.
- Reset mid-playback abandons all channels. Playback requires a key-on after release.

## Structure
- Package pcm_nch_pkg holds:
  - Register index constants (REG_PER_L..REG_KOFF).
  - The ctl field positions.
  - The volume-scale function.
- Sub-module pcm_nch_chan holds one channel's registers, prescaler, address counter and busy/out logic. It is instantiated NCH times via generate.
- The top holds the slot sequencer, write decode, SA mux and TICK.

## Test plan
Defaults throughout.
- Reset: hold NRES low mid-round → SA=0, CH_OUT=0, STATUS=0, TICK=0. After release, TICK first high at cycle 7.
- One-shot: ch0 period=0xFFF, start=0x00100, vol=15, key-on; ROM[0x100..0x102]=0x10,0x20,0x80 → CH_OUT0 0x10, then 0x20 one round later. On 0x80, STATUS[0]→0 and CH_OUT0 holds 0x20.
- Loop: same as one-shot with loop=1 → sequence 0x10,0x20 repeats with SA returning to 0x100; STATUS[0] stays 1.
- Rate/volume: ch2 period=0xFFE, vol=7, ROM data 0x40 → SA advances every 2 rounds (16 cycles); CH_OUT2=0x20.
- Wrap: ch3 start=0x1FFFF, non-end data, period=0xFFF → next fetch SA=0x00000.
- Collisions: key-off ch1 mid-play → STATUS[1]=0 next cycle, CH_OUT1 held. Key-on ch1 in its phase-1 cycle → addr=start, capture discarded.

Source files
------------

// File: rtl/pcm_nch_pkg.sv
// pcm_nch_pkg
//   Shared definitions for the N-channel PCM sample player:
//   per-channel register indices, control-register field positions and
//   the volume scaling function used by every channel.
package pcm_nch_pkg;

    // Per-channel register map (low three address bits)
    localparam logic [2:0] REG_PER_L = 3'd0;  // period[7:0]
    localparam logic [2:0] REG_PER_H = 3'd1;  // period[PW-1:8]
    localparam logic [2:0] REG_ST_L  = 3'd2;  // start[7:0]
    localparam logic [2:0] REG_ST_M  = 3'd3;  // start[15:8]
    localparam logic [2:0] REG_ST_H  = 3'd4;  // start[AW-1:16]
    localparam logic [2:0] REG_CTL   = 3'd5;  // loop / volume
    localparam logic [2:0] REG_KON   = 3'd6;  // key-on strobe
    localparam logic [2:0] REG_KOFF  = 3'd7;  // key-off strobe

    // Control register fields
    localparam int CTL_LOOP    = 0;
    localparam int CTL_VOL_LSB = 4;
    localparam int CTL_VOL_MSB = 7;

    // (smp * (vol + 1)) >> 4 : vol = 15 passes the sample unchanged.
    // Samples up to 16 bits wide; the caller keeps the low DW bits.
    function automatic logic [15:0] vol_scale(input logic [15:0] smp,
                                               input logic [3:0]  vol);
        logic [20:0] prod;
        prod = 21'(smp) * 21'({1'b0, vol} + 5'd1);
        return 16'(prod >> 4);
    endfunction

endpackage

// File: rtl/pcm_nch_chan.sv
// pcm_nch_chan
//   One playback channel: configuration registers, prescaler, address
//   counter, busy flag and the held output sample.
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   wr_i            register write addressed to this channel
//   reg_i, din_i    register index and write data
//   cap_i           this channel's phase-1 (capture) slot
//   sd_i            ROM data {end marker, magnitude}
//   addr_o          current sample address
//   out_o           scaled sample, held between captures
//   busy_o          channel is playing
module pcm_nch_chan
    import pcm_nch_pkg::*;
#(
    parameter int AW = 17,
    parameter int PW = 12,
    parameter int DW = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_i,
    input  logic [2:0]    reg_i,
    input  logic [7:0]    din_i,
    input  logic          cap_i,
    input  logic [DW:0]   sd_i,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] out_o,
    output logic          busy_o
);

    logic [PW-1:0] period_q, period_d;
    logic [AW-1:0] start_q,  start_d;
    logic          loop_q,   loop_d;
    logic [3:0]    vol_q,    vol_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [PW-1:0] pre_q,    pre_d;
    logic          busy_q,   busy_d;
    logic [DW-1:0] out_q,    out_d;
    logic          key_wr;

    // A key strobe on the capture edge pre-empts the capture entirely.
    assign key_wr = wr_i && ((reg_i == REG_KON) || (reg_i == REG_KOFF));

    always_comb begin
        period_d = period_q;
        start_d  = start_q;
        loop_d   = loop_q;
        vol_d    = vol_q;
        addr_d   = addr_q;
        pre_d    = pre_q;
        busy_d   = busy_q;
        out_d    = out_q;

        if (cap_i && busy_q && !key_wr) begin
            if (sd_i[DW]) begin
                if (loop_q) begin
                    addr_d = start_q;
                    pre_d  = period_q;
                end else begin
                    busy_d = 1'b0;
                end
            end else begin
                out_d = DW'(vol_scale(16'(sd_i[DW-1:0]), vol_q));
                // Prescaler counts up from period; step on all-ones.
                if (&pre_q) begin
                    addr_d = addr_q + AW'(1);
                    pre_d  = period_q;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end

        if (wr_i) begin
            case (reg_i)
                REG_PER_L: period_d[7:0]     = din_i;
                REG_PER_H: period_d[PW-1:8]  = din_i[PW-9:0];
                REG_ST_L:  start_d[7:0]      = din_i;
                REG_ST_M:  start_d[15:8]     = din_i;
                REG_ST_H:  start_d[AW-1:16]  = din_i[AW-17:0];
                REG_CTL: begin
                    loop_d = din_i[CTL_LOOP];
                    vol_d  = din_i[CTL_VOL_MSB:CTL_VOL_LSB];
                end
                REG_KON: begin
                    addr_d = start_q;
                    pre_d  = period_q;
                    busy_d = 1'b1;
                end
                REG_KOFF: busy_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_q <= '0;
            start_q  <= '0;
            loop_q   <= 1'b0;
            vol_q    <= '0;
            addr_q   <= '0;
            pre_q    <= '0;
            busy_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            period_q <= period_d;
            start_q  <= start_d;
            loop_q   <= loop_d;
            vol_q    <= vol_d;
            addr_q   <= addr_d;
            pre_q    <= pre_d;
            busy_q   <= busy_d;
            out_q    <= out_d;
        end
    end

    assign addr_o = addr_q;
    assign out_o  = out_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pcm_nch_player.sv
// pcm_nch_player
//   N-channel PCM sample player. A round-robin slot sequencer gives each
//   channel two cycles per round on the shared sample ROM: phase 0 presents
//   the address, phase 1 captures the returned byte.
// Ports
//   clk_i, rst_ni  clock, async active-low reset
//   wr_i           register write strobe
//   addr_i         {channel, reg[2:0]}
//   din_i          register write data
//   sa_o           sample ROM address (combinational from slot/addr)
//   sd_i           ROM data, valid one cycle after sa_o
//   ch_out_o       per-channel scaled samples, channel c at [c*DW +: DW]
//   status_o       per-channel busy
//   tick_o         high in the last cycle of each round
module pcm_nch_player
    import pcm_nch_pkg::*;
#(
    parameter int NCH = 4,
    parameter int AW  = 17,
    parameter int PW  = 12,
    parameter int DW  = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_i,
    input  logic [$clog2(NCH)+2:0] addr_i,
    input  logic [7:0]            din_i,
    output logic [AW-1:0]         sa_o,
    input  logic [DW:0]           sd_i,
    output logic [NCH*DW-1:0]     ch_out_o,
    output logic [NCH-1:0]        status_o,
    output logic                  tick_o
);

    localparam int SW = $clog2(2 * NCH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(2 * NCH - 1);

    logic [SW-1:0] slot_q, slot_d;
    logic [CW-1:0] cur_ch;
    logic [CW-1:0] wr_ch;
    logic [2:0]    wr_reg;
    logic [AW-1:0] addr_arr [NCH];

    always_comb begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) slot_q <= '0;
        else         slot_q <= slot_d;
    end

    assign wr_reg = addr_i[2:0];

    generate
        if (NCH > 1) begin : g_multi
            assign cur_ch = slot_q[SW-1:1];
            assign wr_ch  = addr_i[$clog2(NCH)+2:3];
        end else begin : g_single
            assign cur_ch = 1'b0;
            assign wr_ch  = 1'b0;
        end
    endgenerate

    // Same address in both phases of a channel's slot pair.
    always_comb begin
        sa_o = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cur_ch == CW'(c)) sa_o = addr_arr[c];
        end
    end

    assign tick_o = (slot_q == SLOT_LAST);

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            pcm_nch_chan #(
                .AW (AW),
                .PW (PW),
                .DW (DW)
            ) u_chan (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .wr_i   (wr_i && (wr_ch == CW'(c))),
                .reg_i  (wr_reg),
                .din_i  (din_i),
                .cap_i  (slot_q[0] && (cur_ch == CW'(c))),
                .sd_i   (sd_i),
                .addr_o (addr_arr[c]),
                .out_o  (ch_out_o[c*DW +: DW]),
                .busy_o (status_o[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pcm_nch_player.sv
module tb_pcm_nch_player;
    localparam int NCH = 4;
    localparam int AW  = 17;
    localparam int PW  = 12;
    localparam int DW  = 7;
    localparam int ADW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr = 1'b0;
    logic [ADW-1:0]      addr = '0;
    logic [7:0]          din = '0;
    logic [AW-1:0]       sa;
    logic [DW:0]         sd = '0;
    logic [NCH*DW-1:0]   ch_out;
    logic [NCH-1:0]      status;
    logic                tick;

    logic [7:0] rom [0:(1<<AW)-1];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state (plain integers)
    int m_slot, m_prev_sa;
    int m_per[NCH], m_st[NCH], m_addr[NCH], m_pre[NCH];
    int m_loop[NCH], m_vol[NCH], m_busy[NCH], m_out[NCH];

    pcm_nch_player #(.NCH(NCH), .AW(AW), .PW(PW), .DW(DW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .wr_i     (wr),
        .addr_i   (addr),
        .din_i    (din),
        .sa_o     (sa),
        .sd_i     (sd),
        .ch_out_o (ch_out),
        .status_o (status),
        .tick_o   (tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) sd <= rom[sa];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_slot = 0;
        m_prev_sa = 0;
        for (int c = 0; c < NCH; c++) begin
            m_per[c] = 0; m_st[c] = 0; m_addr[c] = 0; m_pre[c] = 0;
            m_loop[c] = 0; m_vol[c] = 0; m_busy[c] = 0; m_out[c] = 0;
        end
    endtask

    task automatic m_edge();
        int s, wc, wreg, sdv, sa_now;
        bit key;
        s      = m_slot / 2;
        sa_now = m_addr[s];
        sdv    = int'(rom[m_prev_sa]);
        wc     = int'(addr) >> 3;
        wreg   = int'(addr) & 7;
        key    = wr && (wc == s) && (wreg >= 6);
        if ((m_slot % 2 == 1) && (m_busy[s] != 0) && !key) begin
            if (sdv >= 128) begin
                if (m_loop[s] != 0) begin
                    m_addr[s] = m_st[s];
                    m_pre[s]  = m_per[s];
                end else begin
                    m_busy[s] = 0;
                end
            end else begin
                m_out[s] = (sdv * (m_vol[s] + 1)) / 16;
                if (m_pre[s] == (1 << PW) - 1) begin
                    m_addr[s] = (m_addr[s] + 1) % (1 << AW);
                    m_pre[s]  = m_per[s];
                end else begin
                    m_pre[s] = m_pre[s] + 1;
                end
            end
        end
        if (wr && wc < NCH) begin
            case (wreg)
                0: m_per[wc] = (m_per[wc] & 'hF00) | int'(din);
                1: m_per[wc] = (m_per[wc] & 'hFF) | ((int'(din) << 8) & ((1 << PW) - 1));
                2: m_st[wc]  = (m_st[wc] & 'h1FF00) | int'(din);
                3: m_st[wc]  = (m_st[wc] & 'h100FF) | (int'(din) << 8);
                4: m_st[wc]  = (m_st[wc] & 'hFFFF) | ((int'(din) << 16) & ((1 << AW) - 1));
                5: begin m_loop[wc] = int'(din) & 1; m_vol[wc] = int'(din) >> 4; end
                6: begin m_addr[wc] = m_st[wc]; m_pre[wc] = m_per[wc]; m_busy[wc] = 1; end
                default: m_busy[wc] = 0;
            endcase
        end
        m_prev_sa = sa_now;
        m_slot = (m_slot + 1) % (2 * NCH);
    endtask

    task automatic compare_all();
        logic [NCH*DW-1:0] eo;
        logic [NCH-1:0]    es;
        for (int c = 0; c < NCH; c++) begin
            eo[c*DW +: DW] = DW'(m_out[c]);
            es[c]          = (m_busy[c] != 0);
        end
        chk("sa", 32'(sa), 32'(m_addr[m_slot / 2]));
        chk("tick", 32'(tick), 32'(m_slot == 2 * NCH - 1));
        chk("ch_out", 32'(ch_out), 32'(eo));
        chk("status", 32'(status), 32'(es));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) m_edge();
        else       m_reset();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_slot(input int n);
        int k;
        k = 0;
        while (m_slot != n && k < 2 * NCH) begin
            step();
            k++;
        end
    endtask

    task automatic wr_reg(input int c, input int r, input int d);
        wr   = 1'b1;
        addr = ADW'(c * 8 + r);
        din  = 8'(d);
        step();
        wr   = 1'b0;
    endtask

    task automatic prog(input int c, input int per, input int st, input int ctl);
        wr_reg(c, 0, per & 'hFF);
        wr_reg(c, 1, per >> 8);
        wr_reg(c, 2, st & 'hFF);
        wr_reg(c, 3, (st >> 8) & 'hFF);
        wr_reg(c, 4, st >> 16);
        wr_reg(c, 5, ctl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
        rom['h100] = 8'h10; rom['h101] = 8'h20; rom['h102] = 8'h80;
        for (int i = 'h200; i < 'h210; i++) rom[i] = 8'h40;
        rom['h1FFFF] = 8'h05;
        for (int i = 0; i < 16; i++) rom['h300 + i] = 8'(8'h11 + i);
        for (int i = 'h1000; i < 'h1100; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 8'(8'h80 | $urandom_range(0, 127))
                                                   : 8'($urandom_range(0, 127));
        m_reset();
        steps(3);
        rst_n = 1'b1;
        steps(2);

        // One-shot on ch0
        prog(0, 'hFFF, 'h100, 'hF0);
        wait_slot(4);
        wr_reg(0, 6, 0);
        steps(5);
        chk("os_first", 32'(ch_out[6:0]), 32'h10);
        steps(8);
        chk("os_second", 32'(ch_out[6:0]), 32'h20);
        steps(8);
        chk("os_end_busy", 32'(status[0]), 32'h0);
        chk("os_end_hold", 32'(ch_out[6:0]), 32'h20);

        // Loop on ch0
        wr_reg(0, 5, 'hF1);
        wait_slot(4);
        wr_reg(0, 6, 0);
        steps(5);
        chk("lp_first", 32'(ch_out[6:0]), 32'h10);
        steps(16);
        chk("lp_reload_busy", 32'(status[0]), 32'h1);
        chk("lp_reload_hold", 32'(ch_out[6:0]), 32'h20);
        steps(8);
        chk("lp_again", 32'(ch_out[6:0]), 32'h10);
        wr_reg(0, 7, 0);

        // Rate / volume on ch2
        prog(2, 'hFFE, 'h200, 'h70);
        wait_slot(0);
        wr_reg(2, 6, 0);
        steps(32);
        wait_slot(4);
        chk("rate_sa", 32'(sa), 32'h202);
        chk("vol_out", 32'(ch_out[20:14]), 32'h20);
        wr_reg(2, 7, 0);

        // Address wrap on ch3
        prog(3, 'hFFF, 'h1FFFF, 'hF0);
        wait_slot(0);
        wr_reg(3, 6, 0);
        wait_slot(6);
        chk("wrap_pre", 32'(sa), 32'h1FFFF);
        steps(8);
        chk("wrap_sa", 32'(sa), 32'h0);
        wr_reg(3, 7, 0);

        // Collisions on ch1
        prog(1, 'hFFF, 'h300, 'hF0);
        wait_slot(0);
        wr_reg(1, 6, 0);
        steps(16);
        wait_slot(3);
        wr_reg(1, 6, 0);
        chk("kon_cap_out", 32'(ch_out[13:7]), 32'h12);
        chk("kon_cap_busy", 32'(status[1]), 32'h1);
        wait_slot(2);
        chk("kon_cap_sa", 32'(sa), 32'h300);
        steps(2);
        wr_reg(1, 7, 0);
        chk("koff_busy", 32'(status[1]), 32'h0);
        chk("koff_hold", 32'(ch_out[13:7]), 32'h11);
        steps(8);
        chk("koff_hold2", 32'(ch_out[13:7]), 32'h11);

        // Mid-round reset with playback active
        wr_reg(0, 6, 0);
        wr_reg(2, 6, 0);
        steps(19);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_sa", 32'(sa), 32'h0);
        chk("rst_out", 32'(ch_out), 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        steps(3);
        rst_n = 1'b1;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            step();
            n++;
            if (tick) found = 1'b1;
        end
        chk("tick_first", 32'(n), 32'd7);
        steps(16);

        // Randomized register traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int c, r, d;
                c = $urandom_range(0, NCH - 1);
                r = $urandom_range(0, 7);
                d = $urandom_range(0, 255);
                if (r == 0) d = d | 'hF8;
                if (r == 1) d = 'h0F;
                if (r == 3) d = 'h10;
                if (r == 4) d = 0;
                wr_reg(c, r, d);
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
